// File: rtl/writeback_buffer_if.sv
// writeback_buffer_if: eviction capture, memory drain and miss-path forwarding
// signals of the writeback buffer, bundled so the cache side and the buffer
// share one port.
//   master: cache / memory side that drives evictions, acks and lookups
//   slave : the buffer itself
interface writeback_buffer_if #(
  parameter int PTR_WIDTH  = 2,
  parameter int DATA_WIDTH = 16
);
  logic                  store_en;
  logic [15:1]           store_addr;
  logic [DATA_WIDTH-1:0] store_data;
  logic                  full;
  logic                  overflow;
  logic                  mem_wen;
  logic [15:1]           mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [15:1]           fwd_addr;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [PTR_WIDTH:0]    count;

  modport master (
    output store_en, store_addr, store_data, mem_ack, fwd_addr,
    input  full, overflow, mem_wen, mem_waddr, mem_wdata, fwd_hit, fwd_data, count
  );

  modport slave (
    input  store_en, store_addr, store_data, mem_ack, fwd_addr,
    output full, overflow, mem_wen, mem_waddr, mem_wdata, fwd_hit, fwd_data, count
  );
endinterface

// File: rtl/writeback_buffer.sv
// writeback_buffer: FIFO behind the data cache eviction port. Evicted lines are
// queued and drained to memory over a req/ack handshake, while the miss path
// can look up queued lines combinationally so a refill never sees stale data.
// Optional feature macro: WB_COALESCE_EN -- a store hitting a queued non-head
// entry overwrites that entry's data in place instead of allocating.
module writeback_buffer #(
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  writeback_buffer_if.slave bus
);
  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   ONE_COUNT  = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] ONE_PTR    = PTR_WIDTH'(1);

  logic [15:1]           addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PTR_WIDTH-1:0]  head_q, head_d;
  logic [PTR_WIDTH-1:0]  tail_q, tail_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  full;
  logic                  mem_wen;
  logic                  pop;
  logic                  push;
  logic                  coal_hit;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [PTR_WIDTH-1:0]  fwd_idx;

  assign full    = (count_q == FULL_COUNT);
  assign mem_wen = (count_q != '0);

  assign bus.full      = full;
  assign bus.overflow  = overflow_q;
  assign bus.mem_wen   = mem_wen;
  assign bus.mem_waddr = addr_q[head_q];
  assign bus.mem_wdata = data_q[head_q];
  assign bus.count     = count_q;
  assign bus.fwd_hit   = fwd_hit;
  assign bus.fwd_data  = fwd_data;

  // Lookup from the miss path: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_WIDTH'(k);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx] == bus.fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

`ifdef WB_COALESCE_EN
  logic [PTR_WIDTH-1:0] coal_idx;
  logic [PTR_WIDTH-1:0] coal_scan;

  // Find a queued non-head entry with the store address; the head is skipped so
  // the line currently offered to memory never changes mid-handshake.
  always_comb begin
    coal_hit  = 1'b0;
    coal_idx  = head_q;
    coal_scan = head_q;
    for (int k = 1; k < DEPTH; k++) begin
      coal_scan = head_q + PTR_WIDTH'(k);
      if (valid_q[coal_scan] && (addr_q[coal_scan] == bus.store_addr)) begin
        coal_hit = 1'b1;
        coal_idx = coal_scan;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
`endif

  // Next-state for pointers, occupancy and the sticky drop flag; full is the
  // pre-edge value, so a pop at the same edge cannot rescue a store while full.
  always_comb begin
    pop        = mem_wen & bus.mem_ack;
    push       = bus.store_en & ~coal_hit & ~full;
    head_d     = pop  ? head_q + ONE_PTR : head_q;
    tail_d     = push ? tail_q + ONE_PTR : tail_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + ONE_COUNT;
    end else if (pop && !push) begin
      count_d = count_q - ONE_COUNT;
    end
    overflow_d = overflow_q | (bus.store_en & ~coal_hit & full);
  end

  // Register state and update entry storage on push, pop and in-place merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= bus.store_addr;
        data_q[tail_q]  <= bus.store_data;
      end
`ifdef WB_COALESCE_EN
      if (bus.store_en && coal_hit) begin
        data_q[coal_idx] <= bus.store_data;
      end
`endif
    end
  end
endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed bench for writeback_buffer. Expected drains are
// queued when a store is issued; a monitor pops and compares on every accepted
// memory write. Occupancy, flags and forwarding are checked inline.
module tb_writeback_buffer;
  localparam int DEPTH      = 4;
  localparam int PTR_WIDTH  = 2;
  localparam int DATA_WIDTH = 16;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } entry_t;

  logic   clk = 1'b0;
  logic   rst;
  int     checks   = 0;
  int     failures = 0;
  entry_t expQ[$];
  entry_t expItem;

  writeback_buffer_if #(.PTR_WIDTH(PTR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  writeback_buffer #(
    .DEPTH(DEPTH),
    .PTR_WIDTH(PTR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge; optionally record an expected drain.
  task automatic applyStimulus(input logic en, input logic [14:0] addr, input logic [15:0] data,
                               input logic ack, input logic expectPush);
    @(negedge clk);
    bus.store_en   = en;
    bus.store_addr = addr;
    bus.store_data = data;
    bus.mem_ack    = ack;
    if (expectPush) expQ.push_back({addr, data});
    #1;
  endtask

  task automatic idle(input logic ack);
    applyStimulus(1'b0, 15'h0, 16'h0, ack, 1'b0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    bus.store_en = 1'b0;
    bus.mem_ack  = 1'b0;
    rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drain monitor: each accepted memory write must be the oldest expected entry.
  always begin
    @(negedge clk);
    #2;
    if (!rst && bus.mem_wen && bus.mem_ack) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL drain_unexpected actual=%0h/%0h expected=none", bus.mem_waddr, bus.mem_wdata);
      end else begin
        expItem = expQ.pop_front();
        checkOutput("drain_addr", {17'h0, bus.mem_waddr}, {17'h0, expItem.addr});
        checkOutput("drain_data", {16'h0, bus.mem_wdata}, {16'h0, expItem.data});
      end
    end
  end

  initial begin
    bus.store_en   = 1'b0;
    bus.store_addr = '0;
    bus.store_data = '0;
    bus.mem_ack    = 1'b0;
    bus.fwd_addr   = '0;
    rst = 1'b0;
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    #1;
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("rst_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single entry held under a stalled memory, then acked
    applyStimulus(1'b1, 15'h0040, 16'hBEEF, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      checkOutput("hold_mem_wen", 32'(bus.mem_wen), 32'd1);
      checkOutput("hold_waddr", 32'(bus.mem_waddr), 32'h0040);
      checkOutput("hold_wdata", 32'(bus.mem_wdata), 32'hBEEF);
      checkOutput("hold_count", 32'(bus.count), 32'd1);
    end
    idle(1'b1);
    idle(1'b0);
    checkOutput("acked_count", 32'(bus.count), 32'd0);
    checkOutput("acked_mem_wen", 32'(bus.mem_wen), 32'd0);

    // Fill to full, drop a fifth store, drain in order, wrap the tail
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 15'h0A00 + 15'(i), 16'hA0A0 + 16'(i), 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 15'h0E00, 16'hEEEE, 1'b0, 1'b0);
    checkOutput("fill_full", 32'(bus.full), 32'd1);
    checkOutput("fill_count", 32'(bus.count), 32'd4);
    checkOutput("fill_overflow", 32'(bus.overflow), 32'd0);
    idle(1'b0);
    checkOutput("drop_overflow", 32'(bus.overflow), 32'd1);
    checkOutput("drop_count", 32'(bus.count), 32'd4);
    checkOutput("drop_head", 32'(bus.mem_waddr), 32'h0A00);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);
    checkOutput("drained_count", 32'(bus.count), 32'd0);
    checkOutput("drained_overflow_sticky", 32'(bus.overflow), 32'd1);
    applyStimulus(1'b1, 15'h0F00, 16'hF00F, 1'b0, 1'b1);
    idle(1'b0);
    checkOutput("wrap_count", 32'(bus.count), 32'd1);
    checkOutput("wrap_head", 32'(bus.mem_waddr), 32'h0F00);
    applyStimulus(1'b1, 15'h0F01, 16'hF11F, 1'b0, 1'b1);
    applyStimulus(1'b1, 15'h0F02, 16'hF22F, 1'b0, 1'b1);
    bus.fwd_addr = 15'h0F01;
    idle(1'b0);
    checkOutput("pre_rst_count", 32'(bus.count), 32'd3);
    checkOutput("pre_rst_fwd", 32'(bus.fwd_data), 32'hF11F);

    // Asynchronous reset mid-operation, with an ack presented during and after it
    @(negedge clk);
    bus.mem_ack = 1'b1;
    rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("midrst_count", 32'(bus.count), 32'd0);
    checkOutput("midrst_mem_wen", 32'(bus.mem_wen), 32'd0);
    checkOutput("midrst_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    checkOutput("midrst_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    checkOutput("post_rst_count", 32'(bus.count), 32'd0);
    checkOutput("post_rst_mem_wen", 32'(bus.mem_wen), 32'd0);

    // Push and pop at the same edge with two entries queued
    applyStimulus(1'b1, 15'h1001, 16'h1234, 1'b0, 1'b1);
    applyStimulus(1'b1, 15'h1002, 16'h5678, 1'b0, 1'b1);
    applyStimulus(1'b1, 15'h1003, 16'h9ABC, 1'b1, 1'b1);
    checkOutput("pp_before_count", 32'(bus.count), 32'd2);
    idle(1'b0);
    checkOutput("pp_after_count", 32'(bus.count), 32'd2);
    checkOutput("pp_head", 32'(bus.mem_waddr), 32'h1002);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    checkOutput("pp_drained", 32'(bus.count), 32'd0);

    // Forwarding: youngest duplicate wins, same-cycle push invisible, exact address match
    applyStimulus(1'b1, 15'h0100, 16'h1111, 1'b0, 1'b1);
    applyStimulus(1'b1, 15'h0100, 16'h2222, 1'b0, 1'b1);
    bus.fwd_addr = 15'h0200;
    applyStimulus(1'b1, 15'h0200, 16'h3333, 1'b0, 1'b1);
    checkOutput("fwd_same_cycle_hit", 32'(bus.fwd_hit), 32'd0);
    bus.fwd_addr = 15'h0100;
    #1;
    checkOutput("fwd_young_hit", 32'(bus.fwd_hit), 32'd1);
    checkOutput("fwd_young_data", 32'(bus.fwd_data), 32'h2222);
    bus.fwd_addr = 15'h0102;
    #1;
    checkOutput("fwd_miss_hit", 32'(bus.fwd_hit), 32'd0);
    checkOutput("fwd_miss_data", 32'(bus.fwd_data), 32'd0);
    idle(1'b1);
    bus.fwd_addr = 15'h0200;
    #1;
    checkOutput("fwd_next_cycle", 32'(bus.fwd_data), 32'h3333);
    bus.fwd_addr = 15'h0100;
    #1;
    checkOutput("fwd_acking_young", 32'(bus.fwd_data), 32'h2222);
    idle(1'b1);
    checkOutput("fwd_acking_head_hit", 32'(bus.fwd_hit), 32'd1);
    checkOutput("fwd_acking_head_data", 32'(bus.fwd_data), 32'h2222);
    idle(1'b1);
    checkOutput("fwd_after_pop_hit", 32'(bus.fwd_hit), 32'd0);
    idle(1'b0);
    checkOutput("fwd_drained", 32'(bus.count), 32'd0);

    // Store to a queued non-head address while full
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 15'h0300 + 15'(i), 16'hA000 + 16'(i), 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 15'h0302, 16'hC0DE, 1'b0, 1'b0);
    checkOutput("merge_pre_full", 32'(bus.full), 32'd1);
    bus.fwd_addr = 15'h0302;
    idle(1'b0);
    checkOutput("merge_count", 32'(bus.count), 32'd4);
`ifdef WB_COALESCE_EN
    expQ[2].data = 16'hC0DE;
    checkOutput("merge_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("merge_fwd", 32'(bus.fwd_data), 32'hC0DE);
`else
    checkOutput("merge_overflow", 32'(bus.overflow), 32'd1);
    checkOutput("merge_fwd", 32'(bus.fwd_data), 32'hA002);
`endif
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);
    checkOutput("final_count", 32'(bus.count), 32'd0);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
